// File: rtl/ahb3lite_interconnect_arb_port.sv
// AHB3-Lite multi-layer interconnect slave port arbiter.
// Arbitrates MASTERS upstream master-ports onto one downstream slave by
// priority, then round-robin within the winning level. Respects HMASTLOCK,
// rewrites SEQ to NONSEQ on the first beat after a master change.
// Optional starvation aging is compiled in with `define AHB3_ARB_AGING_EN.
`timescale 1ns/1ps

module ahb3lite_interconnect_arb_port #(
    parameter int unsigned HADDR_SIZE    = 32,
    parameter int unsigned HDATA_SIZE    = 32,
    parameter int unsigned MASTERS       = 3,
    parameter int unsigned PRIORITY_BITS = 3,
    parameter int unsigned AGE_LIMIT     = 16
) (
    input  logic                                      HCLK,
    input  logic                                      HRESETn,

    // upstream master-ports
    input  logic [MASTERS-1:0][PRIORITY_BITS-1:0]     mstpriority,
    input  logic [MASTERS-1:0]                        mstHSEL,
    input  logic [MASTERS-1:0][HADDR_SIZE-1:0]        mstHADDR,
    input  logic [MASTERS-1:0][HDATA_SIZE-1:0]        mstHWDATA,
    input  logic [MASTERS-1:0]                        mstHWRITE,
    input  logic [MASTERS-1:0][2:0]                   mstHSIZE,
    input  logic [MASTERS-1:0][2:0]                   mstHBURST,
    input  logic [MASTERS-1:0][3:0]                   mstHPROT,
    input  logic [MASTERS-1:0][1:0]                   mstHTRANS,
    input  logic [MASTERS-1:0]                        mstHMASTLOCK,
    input  logic [MASTERS-1:0]                        mstHREADY,
    output logic [HDATA_SIZE-1:0]                     mstHRDATA,
    output logic                                      mstHREADYOUT,
    output logic                                      mstHRESP,

    // downstream slave
    output logic                                      slv_HSEL,
    output logic [HADDR_SIZE-1:0]                     slv_HADDR,
    output logic [HDATA_SIZE-1:0]                     slv_HWDATA,
    output logic                                      slv_HWRITE,
    output logic [2:0]                                slv_HSIZE,
    output logic [2:0]                                slv_HBURST,
    output logic [3:0]                                slv_HPROT,
    output logic [1:0]                                slv_HTRANS,
    output logic                                      slv_HMASTLOCK,
    output logic                                      slv_HREADYOUT,
    input  logic [HDATA_SIZE-1:0]                     slv_HRDATA,
    input  logic                                      slv_HREADY,
    input  logic                                      slv_HRESP,

    // arbitration control / status
    input  logic [MASTERS-1:0]                        can_switch,
    output logic [MASTERS-1:0]                        granted_master,
    output logic [MASTERS-1:0]                        starved
);

    localparam int unsigned IDX_W   = (MASTERS > 1) ? $clog2(MASTERS) : 1;
    localparam int unsigned NLEVELS = 1 << PRIORITY_BITS;
    localparam int unsigned NPTR    = NLEVELS + 1;
    localparam int unsigned LVL_W   = PRIORITY_BITS + 1;
    localparam logic [LVL_W-1:0] STARVED_LVL = LVL_W'(NLEVELS);

    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    // state
    logic [MASTERS-1:0] grant_q;
    logic [IDX_W-1:0]   addr_idx_q;
    logic [IDX_W-1:0]   data_idx_q;
    logic [IDX_W-1:0]   ptr_q [NPTR];
    logic               first_q;

    // arbitration nets
    logic [MASTERS-1:0]            starved_c;
    logic [MASTERS-1:0][LVL_W-1:0] eff_lvl;
    logic [LVL_W-1:0]              top_lvl;
    logic                          any_req;
    logic [IDX_W-1:0]              rr_ptr;
    logic [IDX_W-1:0]              winner;
    logic                          found;
    logic [31:0]                   cand;
    logic                          switch_c;
    logic                          change_c;

`ifdef AHB3_ARB_AGING_EN
    localparam int unsigned AGE_W = $clog2(AGE_LIMIT + 1);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(AGE_LIMIT);

    logic [AGE_W-1:0] age_q [MASTERS];

    // Per-master wait counters, advanced only on completed slave cycles
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            for (int m = 0; m < MASTERS; m++) age_q[m] <= '0;
        end else if (slv_HREADY) begin
            for (int m = 0; m < MASTERS; m++) begin
                if (mstHSEL[m] && !grant_q[m]) begin
                    if (age_q[m] != AGE_MAX) age_q[m] <= age_q[m] + AGE_W'(1);
                end else begin
                    age_q[m] <= '0;
                end
            end
        end
    end

    // A saturated counter promotes the master above every priority level
    always_comb begin
        starved_c = '0;
        for (int m = 0; m < MASTERS; m++) starved_c[m] = (age_q[m] == AGE_MAX);
    end
`else
    logic [31:0] unused_age_limit;

    assign unused_age_limit = 32'(AGE_LIMIT);
    assign starved_c        = '0;
`endif

    // Effective level per master: starved class sits one above the top priority
    always_comb begin
        eff_lvl = '0;
        for (int m = 0; m < MASTERS; m++) begin
            eff_lvl[m] = starved_c[m] ? STARVED_LVL : {1'b0, mstpriority[m]};
        end
    end

    // Highest effective level among requesting masters
    always_comb begin
        any_req = 1'b0;
        top_lvl = '0;
        for (int m = 0; m < MASTERS; m++) begin
            if (mstHSEL[m] && (!any_req || (eff_lvl[m] > top_lvl))) begin
                top_lvl = eff_lvl[m];
                any_req = 1'b1;
            end
        end
    end

    // Round-robin within the winning level, starting after its last grant
    always_comb begin
        rr_ptr = ptr_q[top_lvl];
        winner = addr_idx_q;
        found  = 1'b0;
        cand   = '0;
        for (int off = 1; off <= MASTERS; off++) begin
            cand = 32'(rr_ptr) + 32'(off);
            if (cand >= 32'(MASTERS)) cand = cand - 32'(MASTERS);
            if (!found && mstHSEL[IDX_W'(cand)] && (eff_lvl[IDX_W'(cand)] == top_lvl)) begin
                winner = IDX_W'(cand);
                found  = 1'b1;
            end
        end
    end

    // Grant may only move at a completed, unlocked transfer boundary
    always_comb begin
        switch_c = slv_HREADY && can_switch[addr_idx_q] && !mstHMASTLOCK[addr_idx_q] && any_req;
        change_c = switch_c && (winner != addr_idx_q);
    end

    // Grant, address/data phase indices, level pointers and first-beat flag
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            grant_q    <= MASTERS'(1);
            addr_idx_q <= '0;
            data_idx_q <= '0;
            first_q    <= 1'b0;
            for (int unsigned l = 0; l < NPTR; l++) ptr_q[l] <= '0;
        end else if (slv_HREADY) begin
            data_idx_q <= addr_idx_q;
            first_q    <= change_c;
            if (switch_c) begin
                grant_q         <= MASTERS'(1) << winner;
                addr_idx_q      <= winner;
                ptr_q[top_lvl]  <= winner;
            end
        end
    end

    // Downstream address phase follows the granted master
    assign slv_HSEL      = mstHSEL[addr_idx_q];
    assign slv_HADDR     = mstHADDR[addr_idx_q];
    assign slv_HWRITE    = mstHWRITE[addr_idx_q];
    assign slv_HSIZE     = mstHSIZE[addr_idx_q];
    assign slv_HBURST    = mstHBURST[addr_idx_q];
    assign slv_HPROT     = mstHPROT[addr_idx_q];
    assign slv_HMASTLOCK = mstHMASTLOCK[addr_idx_q];
    assign slv_HREADYOUT = mstHREADY[addr_idx_q];
    assign slv_HTRANS    = (first_q && (mstHTRANS[addr_idx_q] == HTRANS_SEQ)) ?
                           HTRANS_NONSEQ : mstHTRANS[addr_idx_q];

    // Write data follows the data-phase master
    assign slv_HWDATA    = mstHWDATA[data_idx_q];

    // Response path is a straight pass-through
    assign mstHRDATA     = slv_HRDATA;
    assign mstHREADYOUT  = slv_HREADY;
    assign mstHRESP      = slv_HRESP;

    assign granted_master = grant_q;
    assign starved        = starved_c;

endmodule

// File: tb/tb_ahb3lite_interconnect_arb_port.sv
// Self-checking bench for ahb3lite_interconnect_arb_port (3 masters).
`timescale 1ns/1ps

module tb_ahb3lite_interconnect_arb_port;

    localparam int unsigned M  = 3;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned PB = 3;

    logic HCLK = 1'b0;
    logic HRESETn;

    logic [M-1:0][PB-1:0] mstpriority;
    logic [M-1:0]         mstHSEL, mstHWRITE, mstHMASTLOCK, mstHREADY;
    logic [M-1:0][AW-1:0] mstHADDR;
    logic [M-1:0][DW-1:0] mstHWDATA;
    logic [M-1:0][2:0]    mstHSIZE, mstHBURST;
    logic [M-1:0][3:0]    mstHPROT;
    logic [M-1:0][1:0]    mstHTRANS;
    logic [DW-1:0]        mstHRDATA;
    logic                 mstHREADYOUT, mstHRESP;
    logic                 slv_HSEL, slv_HWRITE, slv_HMASTLOCK, slv_HREADYOUT;
    logic [AW-1:0]        slv_HADDR;
    logic [DW-1:0]        slv_HWDATA, slv_HRDATA;
    logic [2:0]           slv_HSIZE, slv_HBURST;
    logic [3:0]           slv_HPROT;
    logic [1:0]           slv_HTRANS;
    logic                 slv_HREADY, slv_HRESP;
    logic [M-1:0]         can_switch, granted_master, starved;

    ahb3lite_interconnect_arb_port #(
        .HADDR_SIZE(AW), .HDATA_SIZE(DW), .MASTERS(M), .PRIORITY_BITS(PB), .AGE_LIMIT(4)
    ) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .mstpriority(mstpriority), .mstHSEL(mstHSEL), .mstHADDR(mstHADDR),
        .mstHWDATA(mstHWDATA), .mstHWRITE(mstHWRITE), .mstHSIZE(mstHSIZE),
        .mstHBURST(mstHBURST), .mstHPROT(mstHPROT), .mstHTRANS(mstHTRANS),
        .mstHMASTLOCK(mstHMASTLOCK), .mstHREADY(mstHREADY),
        .mstHRDATA(mstHRDATA), .mstHREADYOUT(mstHREADYOUT), .mstHRESP(mstHRESP),
        .slv_HSEL(slv_HSEL), .slv_HADDR(slv_HADDR), .slv_HWDATA(slv_HWDATA),
        .slv_HWRITE(slv_HWRITE), .slv_HSIZE(slv_HSIZE), .slv_HBURST(slv_HBURST),
        .slv_HPROT(slv_HPROT), .slv_HTRANS(slv_HTRANS), .slv_HMASTLOCK(slv_HMASTLOCK),
        .slv_HREADYOUT(slv_HREADYOUT), .slv_HRDATA(slv_HRDATA), .slv_HREADY(slv_HREADY),
        .slv_HRESP(slv_HRESP), .can_switch(can_switch),
        .granted_master(granted_master), .starved(starved)
    );

    always #5 HCLK = ~HCLK;

    typedef enum int {K_GRANT, K_HADDR, K_HTRANS, K_HWDATA, K_STARVED,
                      K_LOCK, K_RDY, K_RDATA, K_RESP, K_SRDYOUT} kind_e;

    typedef struct {
        string       name;
        kind_e       kind;
        logic [31:0] exp;
    } exp_t;

    typedef struct {
        logic [2:0] hsel;
        logic [2:0] cansw;
        logic [2:0] lock;
        logic       rdy;
        logic [5:0] htr;
        logic [2:0] g;
        logic [1:0] t;
        int         d;
    } vec_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic logic [31:0] addr_of(int m);
        return 32'h0000_A000 + 32'(m) * 32'h100;
    endfunction

    function automatic logic [31:0] data_of(int m);
        return 32'hD000_0000 + 32'(m);
    endfunction

    function automatic int oh2i(logic [2:0] g);
        int r = 0;
        for (int i = 0; i < 3; i++) if (g[i]) r = i;
        return r;
    endfunction

    function automatic logic [31:0] actual(kind_e k);
        logic [31:0] a = '0;
        case (k)
            K_GRANT:   a = 32'(granted_master);
            K_HADDR:   a = slv_HADDR;
            K_HTRANS:  a = 32'(slv_HTRANS);
            K_HWDATA:  a = slv_HWDATA;
            K_STARVED: a = 32'(starved);
            K_LOCK:    a = 32'(slv_HMASTLOCK);
            K_RDY:     a = 32'(mstHREADYOUT);
            K_RDATA:   a = mstHRDATA;
            K_RESP:    a = 32'(mstHRESP);
            K_SRDYOUT: a = 32'(slv_HREADYOUT);
            default:   a = '0;
        endcase
        return a;
    endfunction

    task automatic push(string n, kind_e k, logic [31:0] v);
        exp_t e;
        e.name = n;
        e.kind = k;
        e.exp  = v;
        sbq.push_back(e);
    endtask

    task automatic check_all();
        exp_t        e;
        logic [31:0] a;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            a = actual(e.kind);
            n_cmp++;
            if (a !== e.exp) begin
                n_err++;
                $display("FAIL %s: got %h expected %h", e.name, a, e.exp);
            end
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    vec_t vt[12];
    logic [2:0] ag_cs [9];
    logic [2:0] ag_g  [9];
    logic [2:0] ag_s  [9];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        // rr between masters 1/2 at level 5, SEQ rewrite, then a 4-cycle stall
        vt[0]  = '{3'b111, 3'b111, 3'b000, 1'b1, 6'b101010, 3'b010, 2'b10, 0};
        vt[1]  = '{3'b111, 3'b111, 3'b000, 1'b1, 6'b101010, 3'b100, 2'b10, 1};
        vt[2]  = '{3'b111, 3'b111, 3'b000, 1'b1, 6'b101010, 3'b010, 2'b10, 2};
        vt[3]  = '{3'b111, 3'b111, 3'b000, 1'b1, 6'b101010, 3'b100, 2'b10, 1};
        vt[4]  = '{3'b111, 3'b111, 3'b000, 1'b1, 6'b101110, 3'b010, 2'b10, 2};
        vt[5]  = '{3'b111, 3'b000, 3'b000, 1'b1, 6'b101110, 3'b010, 2'b11, 1};
        vt[6]  = '{3'b111, 3'b111, 3'b000, 1'b1, 6'b101010, 3'b100, 2'b10, 1};
        vt[7]  = '{3'b111, 3'b111, 3'b000, 1'b0, 6'b111010, 3'b100, 2'b10, 1};
        vt[8]  = '{3'b111, 3'b111, 3'b000, 1'b0, 6'b111010, 3'b100, 2'b10, 1};
        vt[9]  = '{3'b111, 3'b111, 3'b000, 1'b0, 6'b111010, 3'b100, 2'b10, 1};
        vt[10] = '{3'b111, 3'b111, 3'b000, 1'b0, 6'b111010, 3'b100, 2'b10, 1};
        vt[11] = '{3'b111, 3'b000, 3'b000, 1'b1, 6'b111010, 3'b100, 2'b11, 2};

        // aging run: master 0 at 7, master 2 at 0; master 2 later holds the bus
        for (int i = 0; i < 9; i++) ag_cs[i] = (i < 5) ? 3'b111 : 3'b011;
`ifdef AHB3_ARB_AGING_EN
        ag_g[0] = 3'b001; ag_g[1] = 3'b001; ag_g[2] = 3'b001; ag_g[3] = 3'b001;
        ag_g[4] = 3'b100; ag_g[5] = 3'b100; ag_g[6] = 3'b100; ag_g[7] = 3'b100;
        ag_g[8] = 3'b100;
        ag_s[0] = 3'b000; ag_s[1] = 3'b000; ag_s[2] = 3'b000; ag_s[3] = 3'b100;
        ag_s[4] = 3'b100; ag_s[5] = 3'b000; ag_s[6] = 3'b000; ag_s[7] = 3'b000;
        ag_s[8] = 3'b001;
`else
        for (int i = 0; i < 9; i++) begin
            ag_g[i] = 3'b001;
            ag_s[i] = 3'b000;
        end
`endif

        // reset with idle masters
        HRESETn      = 1'b0;
        mstpriority  = '0;
        mstHSEL      = '0;
        mstHWRITE    = 3'b111;
        mstHMASTLOCK = '0;
        mstHREADY    = 3'b110;
        mstHSIZE     = '0;
        mstHBURST    = '0;
        mstHPROT     = '0;
        mstHTRANS    = 6'b111111;
        for (int m = 0; m < 3; m++) begin
            mstHADDR[m]  = addr_of(m);
            mstHWDATA[m] = data_of(m);
        end
        slv_HRDATA   = 32'h5A5A_1234;
        slv_HREADY   = 1'b1;
        slv_HRESP    = 1'b1;
        can_switch   = 3'b111;
        repeat (2) @(posedge HCLK);
        #1 HRESETn = 1'b1;
        #1;
        push("rst_grant",   K_GRANT,   32'h1);
        push("rst_haddr",   K_HADDR,   addr_of(0));
        push("rst_htrans",  K_HTRANS,  32'h3);
        push("rst_hwdata",  K_HWDATA,  data_of(0));
        push("rst_starved", K_STARVED, 32'h0);
        push("rst_rdata",   K_RDATA,   32'h5A5A_1234);
        push("rst_resp",    K_RESP,    32'h1);
        push("rst_srdyout", K_SRDYOUT, 32'h0);
        check_all();

        // no candidate: grant parks on master 0
        tick();
        push("park_grant",  K_GRANT,  32'h1);
        push("park_htrans", K_HTRANS, 32'h3);
        check_all();

        slv_HRESP   = 1'b0;
        mstHREADY   = 3'b111;
        mstpriority = {3'd5, 3'd5, 3'd3};
        for (int i = 0; i < 12; i++) begin
            mstHSEL      = vt[i].hsel;
            can_switch   = vt[i].cansw;
            mstHMASTLOCK = vt[i].lock;
            slv_HREADY   = vt[i].rdy;
            mstHTRANS    = vt[i].htr;
            push($sformatf("tbl%0d_grant", i),  K_GRANT,  32'(vt[i].g));
            push($sformatf("tbl%0d_haddr", i),  K_HADDR,  addr_of(oh2i(vt[i].g)));
            push($sformatf("tbl%0d_htrans", i), K_HTRANS, 32'(vt[i].t));
            push($sformatf("tbl%0d_hwdata", i), K_HWDATA, data_of(vt[i].d));
            push($sformatf("tbl%0d_rdy", i),    K_RDY,    32'(vt[i].rdy));
            tick();
            check_all();
        end

        // async reset mid-burst on master 2
        HRESETn = 1'b0;
        #2;
        push("midrst_grant",  K_GRANT,  32'h1);
        push("midrst_haddr",  K_HADDR,  addr_of(0));
        push("midrst_htrans", K_HTRANS, 32'h2);
        push("midrst_hwdata", K_HWDATA, data_of(0));
        check_all();
        HRESETn = 1'b1;

        // locked master 0 holds the grant against a higher-priority master 2
        mstpriority  = {3'd6, 3'd0, 3'd1};
        mstHSEL      = 3'b101;
        mstHMASTLOCK = 3'b001;
        can_switch   = 3'b111;
        slv_HREADY   = 1'b1;
        mstHTRANS    = 6'b101010;
        for (int i = 0; i < 3; i++) begin
            push($sformatf("lock%0d_grant", i), K_GRANT, 32'h1);
            push($sformatf("lock%0d_mlock", i), K_LOCK,  32'h1);
            tick();
            check_all();
        end
        mstHMASTLOCK = 3'b000;
        push("unlock_grant", K_GRANT, 32'h4);
        push("unlock_mlock", K_LOCK,  32'h0);
        push("unlock_haddr", K_HADDR, addr_of(2));
        tick();
        check_all();

        // starvation aging
        HRESETn = 1'b0;
        #2 HRESETn = 1'b1;
        mstpriority = {3'd0, 3'd0, 3'd7};
        mstHSEL     = 3'b101;
        for (int i = 0; i < 9; i++) begin
            can_switch = ag_cs[i];
            push($sformatf("age%0d_grant", i),   K_GRANT,   32'(ag_g[i]));
            push($sformatf("age%0d_starved", i), K_STARVED, 32'(ag_s[i]));
            tick();
            check_all();
        end

        // async reset clears grant and starvation immediately
        HRESETn = 1'b0;
        #2;
        push("agerst_grant",   K_GRANT,   32'h1);
        push("agerst_starved", K_STARVED, 32'h0);
        push("agerst_haddr",   K_HADDR,   addr_of(0));
        check_all();
        HRESETn = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
